// File: rtl/lock_pkg.sv
// Shared definitions for the keypad door lock sequencer.
//   KEY_STAR / KEY_HASH : key codes for '*' and '#'
//   DIGITS              : default code length in BCD digits
//   lock_state_e        : top-level FSM states
package lock_pkg;

  localparam int unsigned DIGITS = 8;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Width of the shared tick timer; large enough for the longest hold time.
  localparam int unsigned TIMER_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StCheck,
    StOpen,
    StChgNew,
    StChgConf,
    StLockout
  } lock_state_e;

endpackage

// File: rtl/lock_tick_timer.sv
// Counts timebase tick strobes and flags when a compare value is reached.
//   i_clk   : system clock
//   i_rst   : synchronous active-high reset
//   i_clear : load the count to zero (wins over i_tick)
//   i_tick  : one-cycle timebase strobe
//   i_limit : compare value
//   o_done  : count has reached i_limit
module lock_tick_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_tick,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_tick && (r_count != '1)) begin
      // Saturate rather than wrap.
      r_count <= r_count + 1'b1;
    end
  end

  assign o_done = (r_count >= i_limit);

endmodule

// File: rtl/lock_sequencer.sv
// Top-level control FSM for the keypad door lock: code entry, password check,
// unlock hold, two-pass password change, wrong-attempt lockout and inactivity
// timeout.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_key_valid/code   : debounced key strobe; 0-9 digits, 10 '*', 11 '#'
//   i_tick             : slow timebase strobe
//   o_disp             : BCD display, newest digit in [3:0]
//   o_digit_cnt        : digits held in the active buffer
//   o_unlock           : door open
//   o_locked_out       : lockout active
//   o_pw_changed       : one-cycle pulse, password updated
//   o_pw_error         : one-cycle pulse, wrong code or confirm mismatch
//   o_fail_cnt         : consecutive wrong attempts
module lock_sequencer #(
  parameter int unsigned           DIGITS        = lock_pkg::DIGITS,
  parameter logic [4*DIGITS-1:0]   INIT_PASS     = 32'h1234_5678,
  parameter int unsigned           TIMEOUT_TICKS = 3000,
  parameter int unsigned           OPEN_TICKS    = 2500,
  parameter int unsigned           LOCK_TICKS    = 15000,
  parameter int unsigned           MAX_FAILS     = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_key_valid,
  input  logic [3:0]          i_key_code,
  input  logic                i_tick,
  output logic [4*DIGITS-1:0] o_disp,
  output logic [3:0]          o_digit_cnt,
  output logic                o_unlock,
  output logic                o_locked_out,
  output logic                o_pw_changed,
  output logic                o_pw_error,
  output logic [3:0]          o_fail_cnt
);

  import lock_pkg::*;

  localparam int unsigned W = 4 * DIGITS;

  lock_state_e          r_state, w_state_d;
  logic [W-1:0]         r_buf, w_buf_d;
  logic [W-1:0]         r_new_pw, w_new_pw_d;
  logic [W-1:0]         r_pw, w_pw_d;
  logic [3:0]           r_cnt, w_cnt_d;
  logic [3:0]           r_fail, w_fail_d;
  logic                 r_pw_error, w_pw_error_d;
  logic                 r_pw_changed, w_pw_changed_d;

  logic                 w_digit, w_star, w_hash;
  logic                 w_key_accept;
  logic                 w_last;
  logic [W-1:0]         w_shift;
  logic [3:0]           w_fail_inc;
  logic                 w_timer_clear;
  logic                 w_timer_done;
  logic [TIMER_W-1:0]   w_timer_limit;

  assign w_digit    = i_key_valid && (i_key_code <= 4'd9);
  assign w_star     = i_key_valid && (i_key_code == KEY_STAR);
  assign w_hash     = i_key_valid && (i_key_code == KEY_HASH);
  assign w_shift    = {r_buf[W-5:0], i_key_code};
  assign w_last     = (r_cnt == 4'(DIGITS - 1));
  assign w_fail_inc = r_fail + 4'd1;

  // One timer shared by all timed states; the compare value follows the state.
  always_comb begin
    w_timer_limit = '1;
    unique case (r_state)
      StEntry, StChgNew, StChgConf: w_timer_limit = TIMER_W'(TIMEOUT_TICKS);
      StOpen:                       w_timer_limit = TIMER_W'(OPEN_TICKS);
      StLockout:                    w_timer_limit = TIMER_W'(LOCK_TICKS);
      default:                      w_timer_limit = '1;
    endcase
  end

  // Cleared on every state change, so a tick in the transition cycle is lost.
  assign w_timer_clear = (w_state_d != r_state) || w_key_accept;

  lock_tick_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_timer_clear),
    .i_tick  (i_tick),
    .i_limit (w_timer_limit),
    .o_done  (w_timer_done)
  );

  always_comb begin
    w_state_d      = r_state;
    w_buf_d        = r_buf;
    w_cnt_d        = r_cnt;
    w_new_pw_d     = r_new_pw;
    w_pw_d         = r_pw;
    w_fail_d       = r_fail;
    w_pw_error_d   = 1'b0;
    w_pw_changed_d = 1'b0;
    w_key_accept   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_star) begin
          w_state_d = StEntry;
        end
      end
      StEntry: begin
        if (w_timer_done) begin
          w_state_d = StIdle;
        end else if (w_star) begin
          w_key_accept = 1'b1;
          w_buf_d      = '0;
          w_cnt_d      = '0;
        end else if (w_digit) begin
          w_key_accept = 1'b1;
          w_buf_d      = w_shift;
          w_cnt_d      = r_cnt + 4'd1;
          if (w_last) begin
            w_state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (r_buf == r_pw) begin
          w_state_d = StOpen;
          w_fail_d  = '0;
        end else begin
          w_pw_error_d = 1'b1;
          w_fail_d     = w_fail_inc;
          w_state_d    = (w_fail_inc == 4'(MAX_FAILS)) ? StLockout : StIdle;
        end
      end
      StOpen: begin
        if (w_star) begin
          w_state_d = StIdle;
        end else if (w_hash) begin
          w_state_d = StChgNew;
        end else if (w_timer_done) begin
          w_state_d = StIdle;
        end
      end
      StChgNew: begin
        if (w_timer_done || w_star) begin
          w_state_d = StIdle;
        end else if (w_digit) begin
          w_key_accept = 1'b1;
          if (w_last) begin
            w_new_pw_d = w_shift;
            w_buf_d    = '0;
            w_cnt_d    = '0;
            w_state_d  = StChgConf;
          end else begin
            w_buf_d = w_shift;
            w_cnt_d = r_cnt + 4'd1;
          end
        end
      end
      StChgConf: begin
        if (w_timer_done || w_star) begin
          w_state_d = StIdle;
        end else if (w_digit) begin
          w_key_accept = 1'b1;
          if (w_last) begin
            w_state_d = StIdle;
            if (w_shift == r_new_pw) begin
              w_pw_d         = r_new_pw;
              w_pw_changed_d = 1'b1;
            end else begin
              w_pw_error_d = 1'b1;
            end
          end else begin
            w_buf_d = w_shift;
            w_cnt_d = r_cnt + 4'd1;
          end
        end
      end
      StLockout: begin
        if (w_timer_done) begin
          w_state_d = StIdle;
          w_fail_d  = '0;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    // Entry buffers only survive within entry states and the compare cycle,
    // so the display reads zero everywhere else without a separate mux.
    if ((w_state_d == StIdle) || (w_state_d == StOpen) || (w_state_d == StLockout)) begin
      w_buf_d    = '0;
      w_cnt_d    = '0;
      w_new_pw_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_buf        <= '0;
      r_cnt        <= '0;
      r_new_pw     <= '0;
      r_pw         <= INIT_PASS;
      r_fail       <= '0;
      r_pw_error   <= 1'b0;
      r_pw_changed <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_buf        <= w_buf_d;
      r_cnt        <= w_cnt_d;
      r_new_pw     <= w_new_pw_d;
      r_pw         <= w_pw_d;
      r_fail       <= w_fail_d;
      r_pw_error   <= w_pw_error_d;
      r_pw_changed <= w_pw_changed_d;
    end
  end

  // The finished code stays visible during the one-cycle compare.
  assign o_disp       = r_buf;
  assign o_digit_cnt  = r_cnt;
  assign o_unlock     = (r_state == StOpen);
  assign o_locked_out = (r_state == StLockout);
  assign o_pw_changed = r_pw_changed;
  assign o_pw_error   = r_pw_error;
  assign o_fail_cnt   = r_fail;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed self-checking bench for lock_sequencer with short timer settings.
module tb_lock_sequencer;

  localparam logic [3:0] STAR = 4'd10;
  localparam logic [3:0] HASH = 4'd11;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        tick;
  logic [31:0] disp;
  logic [3:0]  digit_cnt;
  logic        unlock;
  logic        locked_out;
  logic        pw_changed;
  logic        pw_error;
  logic [3:0]  fail_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  lock_sequencer #(
    .DIGITS        (8),
    .INIT_PASS     (32'h1234_5678),
    .TIMEOUT_TICKS (10),
    .OPEN_TICKS    (5),
    .LOCK_TICKS    (20),
    .MAX_FAILS     (3)
  ) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_key_valid  (key_valid),
    .i_key_code   (key_code),
    .i_tick       (tick),
    .o_disp       (disp),
    .o_digit_cnt  (digit_cnt),
    .o_unlock     (unlock),
    .o_locked_out (locked_out),
    .o_pw_changed (pw_changed),
    .o_pw_error   (pw_error),
    .o_fail_cnt   (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the falling edge.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic pulse_tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic press_digits(input logic [31:0] code);
    for (int i = 7; i >= 0; i--) begin
      press(code[4*i +: 4]);
    end
  endtask

  // '*' then eight digits; returns in the compare cycle.
  task automatic enter_code(input logic [31:0] code);
    press(STAR);
    press_digits(code);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_disp"}, disp, 32'h0);
    check({tag, "_cnt"}, {28'h0, digit_cnt}, 32'h0);
    check({tag, "_outs"}, {28'h0, unlock, locked_out, pw_changed, pw_error}, 32'h0);
    check({tag, "_fail"}, {28'h0, fail_cnt}, 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    tick      = 1'b0;
    do_reset();
    check_all_zero("reset");

    // Correct code, unlock latency and hold time.
    press(STAR);
    press_digits(32'h1234_5678 >> 4);  // 0,1,..,7 -> seven meaningful digits
    check("entry_disp7", disp, 32'h0123_4567);
    check("entry_cnt8_pre", {28'h0, digit_cnt}, 32'd8);
    do_reset();
    press(STAR);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    press(4'd12);
    press(HASH);
    check("ignored_keys_cnt", {28'h0, digit_cnt}, 32'd4);
    press(4'd5); press(4'd6); press(4'd7);
    check("disp7", disp, 32'h0123_4567);
    press(4'd8);
    check("disp_last", disp, 32'h1234_5678);
    check("unlock_n1", {31'h0, unlock}, 32'd0);
    @(negedge clk);
    check("unlock_n2", {31'h0, unlock}, 32'd1);
    check("open_disp", disp, 32'h0);
    check("open_fail", {28'h0, fail_cnt}, 32'd0);
    pulse_tick(4);
    check("unlock_4ticks", {31'h0, unlock}, 32'd1);
    pulse_tick(1);
    @(negedge clk);
    check("unlock_5ticks", {31'h0, unlock}, 32'd0);

    // Three wrong codes -> lockout.
    for (int i = 1; i <= 3; i++) begin
      enter_code(32'h8765_4321);
      @(negedge clk);
      check("wrong_pw_error", {31'h0, pw_error}, 32'd1);
      check("wrong_fail_cnt", {28'h0, fail_cnt}, 32'(i));
      @(negedge clk);
      check("wrong_pw_error_off", {31'h0, pw_error}, 32'd0);
    end
    check("locked_out", {31'h0, locked_out}, 32'd1);
    press(STAR);
    press(4'd1);
    check("lock_ignore_cnt", {28'h0, digit_cnt}, 32'd0);
    check("lock_ignore_disp", disp, 32'h0);
    pulse_tick(19);
    check("lock_19ticks", {31'h0, locked_out}, 32'd1);
    pulse_tick(1);
    @(negedge clk);
    check("lock_released", {31'h0, locked_out}, 32'd0);
    check("lock_fail_clr", {28'h0, fail_cnt}, 32'd0);

    // Password change to 99999999.
    enter_code(32'h1234_5678);
    @(negedge clk);
    press(HASH);
    check("chg_unlock_drop", {31'h0, unlock}, 32'd0);
    press_digits(32'h9999_9999);
    check("chg_conf_cnt", {28'h0, digit_cnt}, 32'd0);
    press_digits(32'h9999_9999);
    check("pw_changed", {31'h0, pw_changed}, 32'd1);
    @(negedge clk);
    check("pw_changed_off", {31'h0, pw_changed}, 32'd0);
    enter_code(32'h9999_9999);
    @(negedge clk);
    check("new_pw_unlock", {31'h0, unlock}, 32'd1);
    press(STAR);
    check("star_closes", {31'h0, unlock}, 32'd0);
    enter_code(32'h1234_5678);
    @(negedge clk);
    check("old_pw_error", {31'h0, pw_error}, 32'd1);
    check("old_pw_fail", {28'h0, fail_cnt}, 32'd1);

    // Reset in the middle of a second change restores the initial password.
    enter_code(32'h9999_9999);
    @(negedge clk);
    press(HASH);
    press_digits(32'h1111_2222);
    press(4'd3); press(4'd4); press(4'd5);
    check("conf_disp", disp, 32'h0000_0345);
    do_reset();
    check_all_zero("midreset");
    enter_code(32'h1234_5678);
    @(negedge clk);
    check("init_pw_after_rst", {31'h0, unlock}, 32'd1);

    // Confirm mismatch keeps the password.
    press(HASH);
    press_digits(32'h1234_5678);
    press_digits(32'h1234_5679);
    check("mismatch_error", {31'h0, pw_error}, 32'd1);
    check("mismatch_fail", {28'h0, fail_cnt}, 32'd0);
    check("mismatch_changed", {31'h0, pw_changed}, 32'd0);
    enter_code(32'h1234_5678);
    @(negedge clk);
    check("pw_kept", {31'h0, unlock}, 32'd1);
    press(STAR);

    // Inactivity timeout.
    press(STAR); press(4'd1); press(4'd2);
    check("to_disp_before", disp, 32'h12);
    pulse_tick(10);
    @(negedge clk);
    check("to_disp", disp, 32'h0);
    check("to_cnt", {28'h0, digit_cnt}, 32'd0);
    check("to_no_error", {31'h0, pw_error}, 32'd0);

    // Key and tick together clear the timer.
    press(STAR); press(4'd1); press(4'd2);
    pulse_tick(8);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'd3;
    tick      = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    tick      = 1'b0;
    pulse_tick(9);
    @(negedge clk);
    check("keytick_cnt", {28'h0, digit_cnt}, 32'd3);
    check("keytick_disp", disp, 32'h123);
    pulse_tick(1);
    @(negedge clk);
    check("keytick_timeout", {28'h0, digit_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
